// File: rtl/gru_weight_readback.sv
// Snapshots the weight_loader flat vectors on start and streams them out word by word
// with tensor-id/index/last tags. Define GRU_READBACK_CHECKSUM_EN to append a sum word.
module gru_weight_readback #(
    parameter int DATA_WIDTH     = 32,
    parameter int INPUT_FEATURES = 3,
    parameter int GRU_UNITS      = 3
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           i_start,
    input  logic                                           i_weights_valid,
    input  logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0] i_Wr_flat,
    input  logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0] i_Wz_flat,
    input  logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0] i_Wh_flat,
    input  logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]      i_Ur_flat,
    input  logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]      i_Uz_flat,
    input  logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]      i_Uh_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]                i_br_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]                i_bz_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]                i_bh_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]                i_fc_weights_flat,
    input  logic [DATA_WIDTH-1:0]                          i_fc_bias,
    output logic [DATA_WIDTH-1:0]                          o_tdata,
    output logic                                           o_tvalid,
    input  logic                                           i_tready,
    output logic                                           o_tlast,
    output logic [3:0]                                     o_tensor_id,
    output logic [7:0]                                     o_index,
    output logic                                           o_busy,
    output logic                                           o_done,
    output logic                                           o_error
);

    localparam int W_LEN   = GRU_UNITS * INPUT_FEATURES;
    localparam int U_LEN   = GRU_UNITS * GRU_UNITS;
    localparam int B_LEN   = GRU_UNITS;
    localparam int N_WORDS = 3 * W_LEN + 3 * U_LEN + 4 * B_LEN + 1;
`ifdef GRU_READBACK_CHECKSUM_EN
    localparam int N_TOTAL = N_WORDS + 1;
`else
    localparam int N_TOTAL = N_WORDS;
`endif
    localparam int PTR_W   = $clog2(N_TOTAL);
    localparam int MAX_LEN = (W_LEN > U_LEN) ? W_LEN : U_LEN;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_TOTAL - 1);

    // o_index is 8 bits wide, so no tensor may hold more than 256 elements.
    generate
        if (MAX_LEN > 256) begin : g_param_check
            $error("gru_weight_readback: largest tensor exceeds 256 elements");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                          state, state_nxt;
    logic [N_WORDS*DATA_WIDTH-1:0]   stream_flat;
    logic [N_WORDS*DATA_WIDTH-1:0]   snap_flat;
    logic [PTR_W-1:0]                ptr;
    logic [3:0]                      tensor_id;
    logic [7:0]                      index;
    logic                            error_q;
    logic [DATA_WIDTH-1:0]           rd_word;
    logic                            start_ok;
    logic                            start_rej;
    logic                            xfer;
    logic                            tensor_end;

    // Word 0 sits in the LSBs, so the concatenation lists tensors in reverse stream order.
    assign stream_flat = {i_fc_bias, i_fc_weights_flat, i_bh_flat, i_Uh_flat, i_Wh_flat,
                          i_bz_flat, i_Uz_flat, i_Wz_flat, i_br_flat, i_Ur_flat, i_Wr_flat};

    function automatic logic [8:0] tensor_len(input logic [3:0] id);
        case (id)
            4'd0, 4'd3, 4'd6:       tensor_len = 9'(W_LEN);
            4'd1, 4'd4, 4'd7:       tensor_len = 9'(U_LEN);
            4'd2, 4'd5, 4'd8, 4'd9: tensor_len = 9'(B_LEN);
            default:                tensor_len = 9'd1;
        endcase
    endfunction

    assign start_ok   = (state == S_IDLE) && i_start && i_weights_valid;
    assign start_rej  = (state == S_IDLE) && i_start && !i_weights_valid;
    assign xfer       = (state == S_SEND) && i_tready;
    assign tensor_end = ({1'b0, index} == (tensor_len(tensor_id) - 9'd1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of the order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal driven in an always_comb gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_SEND;
            S_SEND:  if (xfer && (ptr == LAST_PTR)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state == S_SEND);
        o_tvalid    = (state == S_SEND);
        o_done      = (state == S_DONE);
        o_error     = error_q;
        o_tdata     = '0;
        o_tensor_id = '0;
        o_index     = '0;
        o_tlast     = 1'b0;
        if (state == S_SEND) begin
            o_tdata     = rd_word;
            o_tensor_id = tensor_id;
            o_index     = index;
            o_tlast     = (ptr == LAST_PTR);
        end
    end

    // NOTE: the snapshot is a plain register bank rather than a RAM, so it takes the
    // async reset like any other flop and reads back as zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_flat <= '0;
            ptr       <= '0;
            tensor_id <= '0;
            index     <= '0;
            error_q   <= 1'b0;
        end else begin
            error_q <= start_rej;
            if (start_ok) begin
                snap_flat <= stream_flat;
                ptr       <= '0;
                tensor_id <= '0;
                index     <= '0;
            end else if (xfer && (ptr != LAST_PTR)) begin
                ptr <= ptr + PTR_W'(1);
                if (tensor_end) begin
                    tensor_id <= tensor_id + 4'd1;
                    index     <= '0;
                end else begin
                    index <= index + 8'd1;
                end
            end
        end
    end

`ifdef GRU_READBACK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          csum <= '0;
        else if (start_ok)  csum <= '0;
        else if (xfer)      csum <= csum + rd_word;
    end
`endif

    // Word select from the snapshot; the checksum slot follows the last weight word.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (ptr == PTR_W'(k)) rd_word = snap_flat[k*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef GRU_READBACK_CHECKSUM_EN
        if (ptr == PTR_W'(N_WORDS)) rd_word = csum;
`endif
    end

endmodule

// File: tb/tb_gru_weight_readback.sv
// Self-checking bench for gru_weight_readback: streams are compared against a
// tensor-order model built from the flat inputs (checksum word when GRU_READBACK_CHECKSUM_EN).
module tb_gru_weight_readback;

    localparam int DW = 32;
    localparam int IF = 3;
    localparam int GU = 3;
    localparam int WL = GU * IF;
    localparam int UL = GU * GU;
    localparam int BL = GU;
`ifdef GRU_READBACK_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            i_start = 1'b0;
    logic            i_weights_valid = 1'b0;
    logic [WL*DW-1:0] wr = '0, wz = '0, wh = '0;
    logic [UL*DW-1:0] ur = '0, uz = '0, uh = '0;
    logic [BL*DW-1:0] br = '0, bz = '0, bh = '0, fcw = '0;
    logic [DW-1:0]   fcb = '0;
    logic [DW-1:0]   o_tdata;
    logic            o_tvalid;
    logic            i_tready = 1'b0;
    logic            o_tlast;
    logic [3:0]      o_tensor_id;
    logic [7:0]      o_index;
    logic            o_busy, o_done, o_error;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_data[$];
    int            exp_tid[$];
    int            exp_idx[$];

    always #5 clk = ~clk;

    gru_weight_readback #(
        .DATA_WIDTH(DW), .INPUT_FEATURES(IF), .GRU_UNITS(GU)
    ) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_weights_valid(i_weights_valid),
        .i_Wr_flat(wr), .i_Wz_flat(wz), .i_Wh_flat(wh),
        .i_Ur_flat(ur), .i_Uz_flat(uz), .i_Uh_flat(uh),
        .i_br_flat(br), .i_bz_flat(bz), .i_bh_flat(bh), .i_fc_weights_flat(fcw),
        .i_fc_bias(fcb),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
        .o_tensor_id(o_tensor_id), .o_index(o_index),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    // Stream order: Wr Ur br Wz Uz bz Wh Uh bh fc_w fc_bias.
    function automatic int tlen(input int t);
        case (t)
            0, 3, 6:    return WL;
            1, 4, 7:    return UL;
            2, 5, 8, 9: return BL;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [DW-1:0] get_w(input int t, input int e);
        case (t)
            0:  return wr[e*DW +: DW];
            1:  return ur[e*DW +: DW];
            2:  return br[e*DW +: DW];
            3:  return wz[e*DW +: DW];
            4:  return uz[e*DW +: DW];
            5:  return bz[e*DW +: DW];
            6:  return wh[e*DW +: DW];
            7:  return uh[e*DW +: DW];
            8:  return bh[e*DW +: DW];
            9:  return fcw[e*DW +: DW];
            default: return fcb;
        endcase
    endfunction

    task automatic set_w(input int t, input int e, input logic [DW-1:0] v);
        case (t)
            0:  wr[e*DW +: DW] = v;
            1:  ur[e*DW +: DW] = v;
            2:  br[e*DW +: DW] = v;
            3:  wz[e*DW +: DW] = v;
            4:  uz[e*DW +: DW] = v;
            5:  bz[e*DW +: DW] = v;
            6:  wh[e*DW +: DW] = v;
            7:  uh[e*DW +: DW] = v;
            8:  bh[e*DW +: DW] = v;
            9:  fcw[e*DW +: DW] = v;
            default: fcb = v;
        endcase
    endtask

    task automatic fill_seq();
        int k = 0;
        for (int t = 0; t < 11; t++)
            for (int e = 0; e < tlen(t); e++) begin
                set_w(t, e, DW'(k + 1));
                k++;
            end
    endtask

    task automatic fill_rand();
        for (int t = 0; t < 11; t++)
            for (int e = 0; e < tlen(t); e++) set_w(t, e, $urandom());
    endtask

    task automatic build_model();
        logic [DW-1:0] sum = '0;
        exp_data.delete();
        exp_tid.delete();
        exp_idx.delete();
        for (int t = 0; t < 11; t++)
            for (int e = 0; e < tlen(t); e++) begin
                exp_data.push_back(get_w(t, e));
                exp_tid.push_back(t);
                exp_idx.push_back(e);
                sum += get_w(t, e);
            end
        if (CSUM) begin
            exp_data.push_back(sum);
            exp_tid.push_back(11);
            exp_idx.push_back(0);
        end
    endtask

    task automatic do_start(input bit valid, input bit corrupt);
        @(negedge clk);
        i_start = 1'b1;
        i_weights_valid = valid;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        if (corrupt) begin
            wr = '1;
            i_weights_valid = 1'b0;
        end
    endtask

    // Consumes one stream from the current point up to o_done, checking every handshake.
    task automatic collect(input bit rand_ready, input int stall_at, input string tag);
        int n = 0, cyc = 0, stall_left = 5, last_cyc = -1, done_cyc = -1;
        bit prev_stall = 1'b0, started = 1'b0, rdy, exp_last;
        logic [DW-1:0] pd;
        logic [3:0] pt;
        logic [7:0] pi;
        logic pl;
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (o_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s first_valid: o_tvalid=%b want 1", tag, o_tvalid);
                end
            end
            if (o_done === 1'b1) begin
                done_cyc = cyc;
            end else if (o_tvalid === 1'b1) begin
                started = 1'b1;
                if (prev_stall) begin
                    checks++;
                    if ({o_tdata, o_tensor_id, o_index, o_tlast} !== {pd, pt, pi, pl}) begin
                        errors++;
                        $display("FAIL %s stall_hold word %0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                                 tag, n, o_tdata, o_tensor_id, o_index, o_tlast, pd, pt, pi, pl);
                    end
                end
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (n == stall_at && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
                i_tready = rdy;
                if (rdy) begin
                    checks++;
                    if (n >= exp_data.size()) begin
                        errors++;
                        $display("FAIL %s extra_word %0d: got %h want none", tag, n, o_tdata);
                    end else begin
                        exp_last = (n == exp_data.size() - 1);
                        if (o_tdata !== exp_data[n] || o_tensor_id !== 4'(exp_tid[n]) ||
                            o_index !== 8'(exp_idx[n]) || o_tlast !== exp_last) begin
                            errors++;
                            $display("FAIL %s word %0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                                     tag, n, o_tdata, o_tensor_id, o_index, o_tlast,
                                     exp_data[n], exp_tid[n], exp_idx[n], exp_last);
                        end
                    end
                    n++;
                    last_cyc = cyc;
                end
                prev_stall = !rdy;
                pd = o_tdata; pt = o_tensor_id; pi = o_index; pl = o_tlast;
            end else if (started) begin
                checks++;
                errors++;
                $display("FAIL %s valid_gap after word %0d: o_tvalid=0 want 1", tag, n);
            end
        end
        checks++;
        if (done_cyc < 0 || n != exp_data.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d done=%0d want %0d", tag, n, done_cyc >= 0, exp_data.size());
        end
        checks++;
        if (done_cyc != last_cyc + 1 || o_busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done_cyc=%0d busy=%b valid=%b want %0d/0/0",
                     tag, done_cyc, o_busy, o_tvalid, last_cyc + 1);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_tdata, o_tvalid, o_tlast, o_tensor_id, o_index, o_busy, o_done, o_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h valid=%b busy=%b want all 0", o_tdata, o_tvalid, o_busy);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_tvalid, o_busy, o_done, o_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got v/b/d/e=%b%b%b%b want 0000", o_tvalid, o_busy, o_done, o_error);
        end
    endtask

    task automatic test_full_throughput();
        fill_seq();
        build_model();
        do_start(1'b1, 1'b0);
        collect(1'b0, -1, "full_throughput");
    endtask

    task automatic test_backpressure();
        fill_seq();
        build_model();
        do_start(1'b1, 1'b0);
        collect(1'b1, 20, "backpressure");
    endtask

    task automatic test_reject();
        do_start(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (o_error !== 1'b1 || o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse: got err=%b valid=%b busy=%b want 1/0/0", o_error, o_tvalid, o_busy);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_error !== 1'b0 || o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reject_after: got err=%b valid=%b busy=%b want 0/0/0", o_error, o_tvalid, o_busy);
            end
        end
    endtask

    task automatic test_snapshot();
        fill_seq();
        build_model();
        do_start(1'b1, 1'b1);
        collect(1'b0, -1, "snapshot");
        i_weights_valid = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n = 0, cyc = 0;
        fill_seq();
        build_model();
        i_tready = 1'b1;
        do_start(1'b1, 1'b0);
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_tvalid === 1'b1) begin
                if (n == 30) break;
                n++;
            end
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (n != 30 || {o_tdata, o_tvalid, o_tlast, o_tensor_id, o_index, o_busy, o_done, o_error} !== '0) begin
            errors++;
            $display("FAIL reset_mid: reached word %0d, got data=%h valid=%b busy=%b want word 30 and all 0",
                     n, o_tdata, o_tvalid, o_busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tvalid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_restart: got valid=%b busy=%b want 0/0", o_tvalid, o_busy);
        end
        do_start(1'b1, 1'b0);
        collect(1'b0, -1, "after_reset");
    endtask

    task automatic test_random_data();
        fill_rand();
        build_model();
        do_start(1'b1, 1'b0);
        collect(1'b1, $urandom_range(0, 60), "random_data");
    endtask

    task automatic test_back_to_back();
        fill_rand();
        build_model();
        @(negedge clk);
        i_weights_valid = 1'b1;
        i_start = 1'b1;
        collect(1'b0, -1, "b2b_first");
        @(negedge clk);
        i_tready = 1'b0;
        checks++;
        if (o_tvalid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: got valid=%b busy=%b done=%b want 0/0/0", o_tvalid, o_busy, o_done);
        end
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== exp_data[0]) begin
            errors++;
            $display("FAIL b2b_restart: got valid=%b data=%h want 1/%h", o_tvalid, o_tdata, exp_data[0]);
        end
        collect(1'b1, -1, "b2b_second");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_reject();
        test_snapshot();
        test_reset_mid();
        test_random_data();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
